// File: rtl/fifo_rr_drain_arbiter_if.sv
// Bundle between the arbiter, its upstream FIFO bank and the downstream consumer.
interface fifo_rr_drain_arbiter_if #(
  parameter int N_IN       = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int IDX_W = $clog2(N_IN);

  logic [N_IN-1:0]            empty_i;
  logic [N_IN*DATA_WIDTH-1:0] data_i;
  logic [N_IN-1:0]            pop_o;
  logic                       valid_o;
  logic [DATA_WIDTH-1:0]      data_o;
  logic                       ready_i;
  logic [IDX_W-1:0]           gnt_idx_o;
  logic                       busy_o;
  logic [N_IN*16-1:0]         stat_cnt_o;

  // Arbiter side.
  modport master (
    input  empty_i, data_i, ready_i,
    output pop_o, valid_o, data_o, gnt_idx_o, busy_o, stat_cnt_o
  );

  // FIFO bank / consumer side.
  modport slave (
    output empty_i, data_i, ready_i,
    input  pop_o, valid_o, data_o, gnt_idx_o, busy_o, stat_cnt_o
  );
endinterface

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin burst arbiter draining N_IN upstream FIFOs into one valid/ready port.
// Optional per-input saturating pop counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_rr_drain_arbiter #(
  parameter int N_IN       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  fifo_rr_drain_arbiter_if.master arb_io
);
  localparam int IDX_W = $clog2(N_IN);
  localparam int BC_W  = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_IN - 1);
  localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(MAX_BURST - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic [BC_W-1:0]  burst_cnt_q;

  logic                  valid_c;
  logic [DATA_WIDTH-1:0] data_c;
  logic [N_IN-1:0]       pop_c;
  logic                  hs_c;
  logic                  any_req_c;

  // Explicit wrap keeps indices in range for non-power-of-two N_IN.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_LAST) return '0;
    return idx + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_IN-1:0]  empty,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (!found && !empty[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
    return pick;
  endfunction

  // Downstream data is a straight pass-through of the granted FIFO head.
  always_comb begin
    valid_c = 1'b0;
    data_c  = '0;
    pop_c   = '0;
    if (state_q == S_GRANT) begin
      data_c  = arb_io.data_i[int'(gnt_idx_q)*DATA_WIDTH +: DATA_WIDTH];
      valid_c = ~arb_io.empty_i[gnt_idx_q] & ~flush_i;
      if (valid_c && arb_io.ready_i) pop_c[gnt_idx_q] = 1'b1;
    end
  end

  assign hs_c      = valid_c & arb_io.ready_i;
  assign any_req_c = ~&arb_io.empty_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      burst_cnt_q <= '0;
    end else if (flush_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req_c) begin
            gnt_idx_q   <= rr_pick(arb_io.empty_i, rr_ptr_q);
            burst_cnt_q <= '0;
            state_q     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (hs_c) burst_cnt_q <= burst_cnt_q + 1'b1;
          // Release on a drained FIFO or on the last beat of a full burst.
          if (!valid_c || (hs_c && burst_cnt_q == BURST_LAST)) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= wrap_inc(gnt_idx_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign arb_io.valid_o   = valid_c;
  assign arb_io.data_o    = data_c;
  assign arb_io.pop_o     = pop_c;
  assign arb_io.busy_o    = (state_q == S_GRANT);
  assign arb_io.gnt_idx_o = gnt_idx_q;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_q [N_IN];

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_IN; k++) stat_q[k] <= '0;
    end else if (flush_i) begin
      for (int k = 0; k < N_IN; k++) stat_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (pop_c[k]) stat_q[k] <= sat_inc16(stat_q[k]);
      end
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_stat
    assign arb_io.stat_cnt_o[g*16 +: 16] = stat_q[g];
  end
`else
  assign arb_io.stat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Randomized, self-checking bench for fifo_rr_drain_arbiter with a queue-based reference model.
module tb_fifo_rr_drain_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int IW = $clog2(N);

  logic clk;
  logic rst;
  logic flush;

  fifo_rr_drain_arbiter_if #(.N_IN(N), .DATA_WIDTH(DW)) bus ();

  fifo_rr_drain_arbiter #(.N_IN(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(flush),
    .arb_io (bus)
  );

`ifdef FIFO_ARB_STATS_EN
  logic rst_s;
  fifo_rr_drain_arbiter_if #(.N_IN(N), .DATA_WIDTH(DW)) bus_s ();
  fifo_rr_drain_arbiter #(.N_IN(N), .DATA_WIDTH(DW), .MAX_BURST(64)) dut_s (
    .clk_i  (clk),
    .rst_i  (rst_s),
    .flush_i(1'b0),
    .arb_io (bus_s)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int cyc;

  // Upstream FIFO contents, owned by the bench.
  logic [DW-1:0] fq [N][$];

  // Reference model: who owns the port, where the next search starts, beats left in the burst.
  bit m_granted;
  int m_owner;
  int m_next;
  int m_left;
  int m_pops [N];

  function automatic logic [DW-1:0] head(input int k);
    if (fq[k].size() != 0) return fq[k][0];
    return 32'hE000_0000 | DW'(k);
  endfunction

  task automatic reset_model();
    m_granted = 1'b0;
    m_owner   = 0;
    m_next    = 0;
    m_left    = 0;
    for (int k = 0; k < N; k++) begin
      m_pops[k] = 0;
      fq[k].delete();
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      bus.empty_i[k]          = (fq[k].size() == 0);
      bus.data_i[k*DW +: DW]  = head(k);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b0;
    bus.ready_i = 1'b0;
    reset_model();
    drive_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive inputs, compare against the model, then advance the model at the edge.
  task automatic step(input bit rdy, input bit fl,
                      output bit ov, output logic [N-1:0] op, output bit ob,
                      output logic [IW-1:0] og, output logic [DW-1:0] od);
    bit              ev;
    bit              hs;
    logic [DW-1:0]   ed;
    logic [N-1:0]    ep;
    logic [N*16-1:0] es;
    bus.ready_i = rdy;
    flush = fl;
    drive_inputs();
    #1;
    ev = m_granted && !fl && (fq[m_owner].size() != 0);
    hs = ev && rdy;
    ed = m_granted ? head(m_owner) : '0;
    ep = '0;
    if (hs) ep[m_owner] = 1'b1;
    es = '0;
`ifdef FIFO_ARB_STATS_EN
    for (int k = 0; k < N; k++) es[k*16 +: 16] = (m_pops[k] > 65535) ? 16'hFFFF : 16'(m_pops[k]);
`endif
    ov = bus.valid_o; op = bus.pop_o; ob = bus.busy_o; og = bus.gnt_idx_o; od = bus.data_o;
    checks++;
    if (bus.valid_o !== ev) begin
      failures++; $display("FAIL valid_o cyc=%0d got=%0b exp=%0b", cyc, bus.valid_o, ev);
    end
    checks++;
    if (bus.pop_o !== ep) begin
      failures++; $display("FAIL pop_o cyc=%0d got=%b exp=%b", cyc, bus.pop_o, ep);
    end
    checks++;
    if (bus.data_o !== ed) begin
      failures++; $display("FAIL data_o cyc=%0d got=%h exp=%h", cyc, bus.data_o, ed);
    end
    checks++;
    if (bus.busy_o !== m_granted) begin
      failures++; $display("FAIL busy_o cyc=%0d got=%0b exp=%0b", cyc, bus.busy_o, m_granted);
    end
    checks++;
    if (bus.gnt_idx_o !== IW'(m_owner)) begin
      failures++; $display("FAIL gnt_idx_o cyc=%0d got=%0d exp=%0d", cyc, bus.gnt_idx_o, m_owner);
    end
    checks++;
    if (bus.stat_cnt_o !== es) begin
      failures++; $display("FAIL stat_cnt_o cyc=%0d got=%h exp=%h", cyc, bus.stat_cnt_o, es);
    end
    @(posedge clk);
    cyc++;
    if (fl) begin
      m_granted = 1'b0;
      m_next    = 0;
      m_left    = 0;
      for (int k = 0; k < N; k++) m_pops[k] = 0;
    end else if (!m_granted) begin
      for (int i = 0; i < N; i++) begin
        if (!m_granted && fq[(m_next + i) % N].size() != 0) begin
          m_owner   = (m_next + i) % N;
          m_granted = 1'b1;
          m_left    = MB;
        end
      end
    end else begin
      if (hs) begin
        void'(fq[m_owner].pop_front());
        m_pops[m_owner]++;
        m_left--;
      end
      if (!ev || m_left == 0) begin
        m_granted = 1'b0;
        m_next    = (m_owner + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit ov, ob; logic [N-1:0] op; logic [IW-1:0] og; logic [DW-1:0] od;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.pop_o !== '0) begin
      failures++; $display("FAIL reset_ctrl got busy=%0b valid=%0b pop=%b exp 0/0/0", bus.busy_o, bus.valid_o, bus.pop_o);
    end
    checks++;
    if (bus.gnt_idx_o !== '0 || bus.data_o !== '0 || bus.stat_cnt_o !== '0) begin
      failures++; $display("FAIL reset_data got gnt=%0d data=%h stat=%h exp 0", bus.gnt_idx_o, bus.data_o, bus.stat_cnt_o);
    end
    apply_reset();
    fq[3].push_back(32'h3333_0001);
    fq[3].push_back(32'h3333_0002);
    fq[3].push_back(32'h3333_0003);
    step(1'b1, 1'b0, ov, op, ob, og, od);
    step(1'b1, 1'b0, ov, op, ob, og, od);
    // Async assertion mid-cycle must clear the grant without a clock edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.gnt_idx_o !== '0 || bus.pop_o !== '0 || bus.valid_o !== 1'b0) begin
      failures++; $display("FAIL async_reset got busy=%0b gnt=%0d pop=%b valid=%0b exp 0", bus.busy_o, bus.gnt_idx_o, bus.pop_o, bus.valid_o);
    end
    apply_reset();
  endtask

  task automatic test_single_source();
    bit ov, ob; logic [N-1:0] op; logic [IW-1:0] og; logic [DW-1:0] od;
    int nvalid;
    logic [DW-1:0] seen [3];
    bit got;
    apply_reset();
    fq[2].push_back(32'hAAAA_000A);
    fq[2].push_back(32'hBBBB_000B);
    fq[2].push_back(32'hCCCC_000C);
    nvalid = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, ov, op, ob, og, od);
      if (ov) begin
        if (nvalid < 3) seen[nvalid] = od;
        nvalid++;
        checks++;
        if (op !== 4'b0100) begin
          failures++; $display("FAIL single_pop got=%b exp=0100", op);
        end
      end
    end
    checks++;
    if (nvalid != 3) begin
      failures++; $display("FAIL single_count got=%0d exp=3", nvalid);
    end
    checks++;
    if (seen[0] !== 32'hAAAA_000A || seen[1] !== 32'hBBBB_000B || seen[2] !== 32'hCCCC_000C) begin
      failures++; $display("FAIL single_order got=%h,%h,%h exp=aaaa000a,bbbb000b,cccc000c", seen[0], seen[1], seen[2]);
    end
    // Pointer now sits at 3: FIFO 3 must win over FIFO 0.
    fq[0].push_back(32'h0000_0F00);
    fq[3].push_back(32'h0000_0F03);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      step(1'b1, 1'b0, ov, op, ob, og, od);
      if (ob) begin
        got = 1'b1;
        checks++;
        if (og !== 2'd3) begin
          failures++; $display("FAIL single_rrptr got=%0d exp=3", og);
        end
      end
    end
    checks++;
    if (!got) begin
      failures++; $display("FAIL single_rrptr_timeout got=no_grant exp=grant");
    end
  endtask

  task automatic test_rotation();
    bit ov, ob, prev_ob; logic [N-1:0] op; logic [IW-1:0] og; logic [DW-1:0] od;
    int ng, total;
    int gseq [16];
    int gpops [16];
    apply_reset();
    for (int k = 0; k < N; k++)
      for (int w = 0; w < 6; w++) fq[k].push_back({8'(k), 24'(w)});
    ng = 0; total = 0; prev_ob = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step(1'b1, 1'b0, ov, op, ob, og, od);
      if (ob && !prev_ob && ng < 16) begin
        gseq[ng] = int'(og); gpops[ng] = 0; ng++;
      end
      if (op != '0) begin
        total++;
        if (ng > 0) gpops[ng-1]++;
      end
      prev_ob = ob;
    end
    checks++;
    if (ng < 4) begin
      failures++; $display("FAIL rot_grants got=%0d exp>=4", ng);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gseq[i] != i || gpops[i] != MB) begin
          failures++; $display("FAIL rot_grant%0d got idx=%0d pops=%0d exp idx=%0d pops=%0d", i, gseq[i], gpops[i], i, MB);
        end
      end
    end
    checks++;
    if (total != 24) begin
      failures++; $display("FAIL rot_total got=%0d exp=24", total);
    end
  endtask

  task automatic test_backpressure();
    bit ov, ob; logic [N-1:0] op; logic [IW-1:0] og; logic [DW-1:0] od;
    apply_reset();
    fq[1].push_back(32'h1111_5555);
    fq[1].push_back(32'h1111_6666);
    step(1'b0, 1'b0, ov, op, ob, og, od);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, ov, op, ob, og, od);
      checks++;
      if (ov !== 1'b1 || od !== 32'h1111_5555 || op !== '0 || ob !== 1'b1) begin
        failures++; $display("FAIL stall%0d got valid=%0b data=%h pop=%b busy=%0b exp 1/11115555/0000/1", i, ov, od, op, ob);
      end
    end
    step(1'b1, 1'b0, ov, op, ob, og, od);
    checks++;
    if (op !== 4'b0010) begin
      failures++; $display("FAIL stall_release got=%b exp=0010", op);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, ov, op, ob, og, od);
  endtask

  task automatic test_wrap_skip();
    bit ov, ob, prev_ob; logic [N-1:0] op; logic [IW-1:0] og; logic [DW-1:0] od;
    int ng;
    int gseq [2];
    apply_reset();
    fq[2].push_back(32'h2222_0001);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, ov, op, ob, og, od);
    fq[0].push_back(32'h0000_0A0A);
    fq[1].push_back(32'h1111_0B0B);
    ng = 0; prev_ob = 1'b0;
    for (int i = 0; i < 20 && ng < 2; i++) begin
      step(1'b1, 1'b0, ov, op, ob, og, od);
      if (ob && !prev_ob) begin gseq[ng] = int'(og); ng++; end
      prev_ob = ob;
    end
    checks++;
    if (ng < 2) begin
      failures++; $display("FAIL wrap_timeout got=%0d grants exp=2", ng);
    end else begin
      checks++;
      if (gseq[0] != 0 || gseq[1] != 1) begin
        failures++; $display("FAIL wrap_order got=%0d,%0d exp=0,1", gseq[0], gseq[1]);
      end
    end
  endtask

  task automatic test_flush();
    bit ov, ob; logic [N-1:0] op; logic [IW-1:0] og; logic [DW-1:0] od;
    bit got;
    apply_reset();
    for (int w = 0; w < 6; w++) fq[2].push_back(32'h2222_0000 | DW'(w));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, ov, op, ob, og, od);
    fq[0].push_back(32'h0000_F00D);
    fq[0].push_back(32'h0000_BEEF);
    step(1'b1, 1'b1, ov, op, ob, og, od);
    checks++;
    if (op !== '0 || ob !== 1'b1) begin
      failures++; $display("FAIL flush_cycle got pop=%b busy=%0b exp pop=0000 busy=1", op, ob);
    end
    step(1'b1, 1'b0, ov, op, ob, og, od);
    checks++;
    if (ob !== 1'b0) begin
      failures++; $display("FAIL flush_idle got busy=%0b exp=0", ob);
    end
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      step(1'b1, 1'b0, ov, op, ob, og, od);
      if (ob) begin
        got = 1'b1;
        checks++;
        if (og !== 2'd0) begin
          failures++; $display("FAIL flush_next_grant got=%0d exp=0", og);
        end
      end
    end
    checks++;
    if (!got) begin
      failures++; $display("FAIL flush_timeout got=no_grant exp=grant");
    end
  endtask

  task automatic test_random();
    bit ov, ob; logic [N-1:0] op; logic [IW-1:0] og; logic [DW-1:0] od;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) < 4) begin
        int k;
        k = int'($urandom_range(N-1));
        if (fq[k].size() < 8) fq[k].push_back($urandom);
      end
      step($urandom_range(3) != 0, $urandom_range(99) == 0, ov, op, ob, og, od);
    end
  endtask

  task automatic test_stats_sat();
`ifdef FIFO_ARB_STATS_EN
    @(negedge clk);
    rst_s = 1'b0;
    repeat (67000) @(negedge clk);
    checks++;
    if (bus_s.stat_cnt_o[15:0] !== 16'hFFFF) begin
      failures++; $display("FAIL stat_sat got=%h exp=ffff", bus_s.stat_cnt_o[15:0]);
    end
    checks++;
    if (bus_s.stat_cnt_o[N*16-1:16] !== '0) begin
      failures++; $display("FAIL stat_others got=%h exp=0", bus_s.stat_cnt_o[N*16-1:16]);
    end
    #2 rst_s = 1'b1;
    #1;
    checks++;
    if (bus_s.stat_cnt_o !== '0) begin
      failures++; $display("FAIL stat_async_clear got=%h exp=0", bus_s.stat_cnt_o);
    end
`endif
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.ready_i = 1'b0;
    bus.empty_i = '1;
    bus.data_i = '0;
`ifdef FIFO_ARB_STATS_EN
    rst_s = 1'b1;
    bus_s.empty_i = 4'b1110;
    bus_s.data_i = '0;
    bus_s.ready_i = 1'b1;
`endif
    reset_model();
    test_reset();
    test_single_source();
    test_rotation();
    test_backpressure();
    test_wrap_skip();
    test_flush();
    test_random();
    test_stats_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
